lsu_mem_port: RTL and testbench

Parametrised load/store unit between the execute and memory stages of the pipelined core. It replaces the single-cycle, word-only data memory path with a valid/ready request/response port toward an external memory (a BRAM model now, the DDR3 controller later). It supports byte/half/word(/double) accesses with byte enables, lane replication and sign/zero extension. While a transaction is outstanding it holds the pipeline via `o_stall`, and a response timeout bounds the stall.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 69 ++++++
 rtl/lsu_mem_port.sv | 178 +++++++++++++++++
 tb/tb_lsu_mem_port.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_size_e    : access size encoding (funct3[1:0])
//   lsu_state_e   : memory-port FSM states
//   lanes_f/ofs_f : byte-lane count and lane-offset width for a bus width
//   align_mask    : low address bits that must be zero for a given size
//   is_misaligned : misalignment check for an access of a given size
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    function automatic int lanes_f(input int dw);
        return dw / 8;
    endfunction

    function automatic int ofs_f(input int dw);
        return (dw == 64) ? 3 : 2;
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    align_mask = 3'b000;
            SZ_H:    align_mask = 3'b001;
            SZ_W:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    // A double access has no legal alignment on a 32-bit bus.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a, input int dw);
        is_misaligned = (a & align_mask(sz)) != 3'b000;
        if (sz == SZ_D && dw != 64)
            is_misaligned = 1'b1;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the LSU.
//   size_i  : access size (funct3[1:0])
//   uns_i   : zero-extend load result when 1
//   ofs_i   : byte offset of the access within the bus word
//   wdata_i : LSB-justified store data
//   rdata_i : raw bus read data
//   be_o    : byte enables (size mask shifted by the offset)
//   wdata_o : store data replicated across all lanes
//   rdata_o : extracted and sign/zero-extended load data
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                      size_i,
    input  logic                            uns_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] ofs_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    output logic [DATA_WIDTH/8-1:0]         be_o,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [DATA_WIDTH-1:0]           rdata_o
);

    localparam int LANES = lanes_f(DATA_WIDTH);

    logic [7:0]            mask8;
    logic [DATA_WIDTH-1:0] sh;
    logic                  sbit;
    int                    nb;
    int                    nbits;

    always_comb begin
        case (size_i)
            SZ_B:    mask8 = 8'h01;
            SZ_H:    mask8 = 8'h03;
            SZ_W:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
        be_o = LANES'(mask8) << ofs_i;
    end

    // Lane i takes byte (i mod access_bytes) of the store data, which
    // replicates bytes/halves/words across the whole bus.
    always_comb begin
        nb = 1 << size_i;
        if (nb > LANES)
            nb = LANES;
        wdata_o = '0;
        for (int i = 0; i < LANES; i++)
            wdata_o[i*8 +: 8] = wdata_i[(i & (nb - 1))*8 +: 8];
    end

    always_comb begin
        sh = rdata_i >> {ofs_i, 3'b000};
        case (size_i)
            SZ_B:    begin nbits = 8;          sbit = sh[7];            end
            SZ_H:    begin nbits = 16;         sbit = sh[15];           end
            SZ_W:    begin nbits = 32;         sbit = sh[31];           end
            default: begin nbits = DATA_WIDTH; sbit = sh[DATA_WIDTH-1]; end
        endcase
        if (uns_i)
            sbit = 1'b0;
        rdata_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            rdata_o[i] = (i < nbits) ? sh[i] : sbit;
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit with a valid/ready memory port.
//   i_req_*      : load/store request from execute
//   o_stall      : holds the pipeline while a transaction is in flight
//   o_done       : one-cycle completion pulse
//   o_rd_valid   : load data valid (with o_done, loads only)
//   o_rd_data    : extended load result, held until the next completion
//   o_misalign   : completion was a trapped misaligned access
//   o_err        : completion was a response timeout
//   o_mem_*/i_mem_* : request/response port toward memory
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned accesses
// complete immediately with o_misalign=1 and no memory access; otherwise
// the address is force-aligned to the access size.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_req_valid,
    input  logic                    i_req_wr,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_stall,
    output logic                    o_done,
    output logic                    o_rd_valid,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_misalign,
    output logic                    o_err,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic                    o_mem_wr,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rsp_data
);

    localparam int OFS = ofs_f(DATA_WIDTH);

    lsu_state_e            state_q, state_d;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [15:0]           cnt_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  misalign_q;
    logic                  err_q;
    logic                  rdv_q;

    logic                    trap_now;
    logic                    enter_done;
    logic [ADDR_WIDTH-1:0]   addr_aligned;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata_rep;
    logic [DATA_WIDTH-1:0]   rd_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_now = is_misaligned(i_req_size, i_req_addr[2:0], DATA_WIDTH);
`else
    assign trap_now = 1'b0;
`endif

    // Aligned requests are unchanged; misaligned ones that are not trapped
    // are forced onto the size boundary.
    assign addr_aligned = i_req_addr & ~ADDR_WIDTH'(align_mask(i_req_size));
    assign enter_done   = (state_q != ST_DONE) && (state_d == ST_DONE);

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_i  (size_q),
        .uns_i   (uns_q),
        .ofs_i   (addr_q[OFS-1:0]),
        .wdata_i (wdata_q),
        .rdata_i (i_mem_rsp_data),
        .be_o    (be),
        .wdata_o (wdata_rep),
        .rdata_o (rd_ext)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_req_valid) state_d = trap_now ? ST_DONE : ST_REQ;
            ST_REQ:  if (i_mem_req_ready) state_d = wr_q ? ST_DONE : ST_WAIT;
            ST_WAIT: if (i_mem_rsp_valid || cnt_q == 16'(TIMEOUT_CYCLES - 1)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            rdv_q      <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && i_req_valid) begin
                wr_q    <= i_req_wr;
                size_q  <= i_req_size;
                uns_q   <= i_req_unsigned;
                addr_q  <= addr_aligned;
                wdata_q <= i_req_wdata;
            end
            // Held at zero while the request is offered, counts in WAIT.
            if (state_q == ST_REQ)
                cnt_q <= '0;
            else if (state_q == ST_WAIT)
                cnt_q <= cnt_q + 16'd1;
            if (enter_done) begin
                case (state_q)
                    ST_IDLE: begin
                        rd_data_q  <= '0;
                        misalign_q <= 1'b1;
                        err_q      <= 1'b0;
                        rdv_q      <= 1'b0;
                    end
                    ST_REQ: begin
                        rd_data_q  <= '0;
                        misalign_q <= 1'b0;
                        err_q      <= 1'b0;
                        rdv_q      <= 1'b0;
                    end
                    default: begin
                        rd_data_q  <= i_mem_rsp_valid ? rd_ext : '0;
                        misalign_q <= 1'b0;
                        err_q      <= ~i_mem_rsp_valid;
                        rdv_q      <= i_mem_rsp_valid;
                    end
                endcase
            end
        end
    end

    // Memory fields are only driven while the request is offered so that
    // the port reads all-zero outside REQ, including straight after reset.
    always_comb begin
        o_stall         = (state_q == ST_IDLE && i_req_valid && !trap_now)
                          || state_q == ST_REQ || state_q == ST_WAIT;
        o_done          = (state_q == ST_DONE);
        o_rd_valid      = (state_q == ST_DONE) && rdv_q;
        o_rd_data       = rd_data_q;
        o_misalign      = misalign_q;
        o_err           = err_q;
        o_mem_req_valid = 1'b0;
        o_mem_wr        = 1'b0;
        o_mem_addr      = '0;
        o_mem_be        = '0;
        o_mem_wdata     = '0;
        if (state_q == ST_REQ) begin
            o_mem_req_valid = 1'b1;
            o_mem_wr        = wr_q;
            o_mem_addr      = {addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
            o_mem_be        = be;
            o_mem_wdata     = wdata_rep;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid, i_req_wr, i_req_unsigned;
    logic [1:0]  i_req_size;
    logic [31:0] i_req_addr, i_req_wdata;
    logic        o_stall, o_done, o_rd_valid, o_misalign, o_err;
    logic [31:0] o_rd_data;
    logic        o_mem_req_valid, i_mem_req_ready, o_mem_wr;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;

    int n_err = 0;
    int n_chk = 0;

    always #5 i_clk = ~i_clk;

    lsu_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_req_valid(i_req_valid), .i_req_wr(i_req_wr), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_stall(o_stall), .o_done(o_done), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_misalign(o_misalign), .o_err(o_err),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rsp_data(i_mem_rsp_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        i_req_valid    = 1'b1;
        i_req_wr       = wr;
        i_req_size     = sz;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, 64'(o_stall), 0);
        chk({tag, ".done"},  64'(o_done), 0);
        chk({tag, ".rdv"},   64'(o_rd_valid), 0);
        chk({tag, ".rd"},    64'(o_rd_data), 0);
        chk({tag, ".mis"},   64'(o_misalign), 0);
        chk({tag, ".err"},   64'(o_err), 0);
        chk({tag, ".mreq"},  64'(o_mem_req_valid), 0);
        chk({tag, ".mwr"},   64'(o_mem_wr), 0);
        chk({tag, ".maddr"}, 64'(o_mem_addr), 0);
        chk({tag, ".mbe"},   64'(o_mem_be), 0);
        chk({tag, ".mwd"},   64'(o_mem_wdata), 0);
    endtask

    // Load with ready=1 and a response in the first WAIT cycle.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp_maddr,
                           input logic [3:0] exp_be, input logic [31:0] rsp,
                           input logic [31:0] exp_rd);
        present(1'b0, sz, uns, addr, 32'h0);
        #1;
        chk({tag, ".stall_acc"}, 64'(o_stall), 1);
        step();
        i_req_valid = 1'b0;
        #1;
        chk({tag, ".mreq"},  64'(o_mem_req_valid), 1);
        chk({tag, ".mwr"},   64'(o_mem_wr), 0);
        chk({tag, ".maddr"}, 64'(o_mem_addr), 64'(exp_maddr));
        chk({tag, ".mbe"},   64'(o_mem_be), 64'(exp_be));
        step();
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = rsp;
        #1;
        chk({tag, ".wait_stall"}, 64'(o_stall), 1);
        chk({tag, ".wait_done"},  64'(o_done), 0);
        step();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk({tag, ".done"},  64'(o_done), 1);
        chk({tag, ".rdv"},   64'(o_rd_valid), 1);
        chk({tag, ".rd"},    64'(o_rd_data), 64'(exp_rd));
        chk({tag, ".stall_done"}, 64'(o_stall), 0);
        step();
        chk({tag, ".idle_done"}, 64'(o_done), 0);
        chk({tag, ".rd_hold"},   64'(o_rd_data), 64'(exp_rd));
    endtask

    initial begin
        i_reset_n       = 1'b0;
        i_req_valid     = 1'b0;
        i_req_wr        = 1'b0;
        i_req_size      = 2'b00;
        i_req_unsigned  = 1'b0;
        i_req_addr      = '0;
        i_req_wdata     = '0;
        i_mem_req_ready = 1'b1;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        step();
        step();
        chk_all_zero("reset");
        i_reset_n = 1'b1;
        step();

        // Store byte 0xA5 to 0x103
        present(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5);
        #1;
        chk("stb.stall_acc", 64'(o_stall), 1);
        step();
        i_req_valid = 1'b0;
        #1;
        chk("stb.mreq",  64'(o_mem_req_valid), 1);
        chk("stb.mwr",   64'(o_mem_wr), 1);
        chk("stb.maddr", 64'(o_mem_addr), 64'h100);
        chk("stb.mbe",   64'(o_mem_be), 64'h8);
        chk("stb.mwd",   64'(o_mem_wdata), 64'hA5A5_A5A5);
        chk("stb.done_early", 64'(o_done), 0);
        step();
        chk("stb.done",  64'(o_done), 1);
        chk("stb.rdv",   64'(o_rd_valid), 0);
        chk("stb.stall", 64'(o_stall), 0);
        step();
        chk("stb.idle_done", 64'(o_done), 0);

        do_load("lhs",  2'b01, 1'b0, 32'h102, 32'h100, 4'hC, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu",  2'b01, 1'b1, 32'h102, 32'h100, 4'hC, 32'h8001_1234, 32'h0000_8001);
        do_load("lbs",  2'b00, 1'b0, 32'h103, 32'h100, 4'h8, 32'h8000_0000, 32'hFFFF_FF80);
        do_load("lbu",  2'b00, 1'b1, 32'h001, 32'h000, 4'h2, 32'h0000_F000, 32'h0000_00F0);
        do_load("lw",   2'b10, 1'b0, 32'h204, 32'h204, 4'hF, 32'h8765_4321, 32'h8765_4321);

        // Store half with ready held low for 5 cycles
        i_mem_req_ready = 1'b0;
        present(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF);
        step();
        i_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rdy.stall", 64'(o_stall), 1);
            chk("rdy.mreq",  64'(o_mem_req_valid), 1);
            chk("rdy.maddr", 64'(o_mem_addr), 64'h200);
            chk("rdy.mbe",   64'(o_mem_be), 64'hC);
            chk("rdy.mwd",   64'(o_mem_wdata), 64'hBEEF_BEEF);
            chk("rdy.done",  64'(o_done), 0);
            step();
        end
        i_mem_req_ready = 1'b1;
        #1;
        chk("rdy.mreq_last", 64'(o_mem_req_valid), 1);
        step();
        chk("rdy.done_after", 64'(o_done), 1);
        step();

        // Timeout: no response
        present(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        step();
        i_req_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to.wait_done",  64'(o_done), 0);
            chk("to.wait_stall", 64'(o_stall), 1);
            step();
        end
        chk("to.done", 64'(o_done), 1);
        chk("to.err",  64'(o_err), 1);
        chk("to.rdv",  64'(o_rd_valid), 0);
        chk("to.rd",   64'(o_rd_data), 0);
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = 32'h1234_5678;
        step();
        i_mem_rsp_valid = 1'b0;
        #1;
        chk("to.late_done",  64'(o_done), 0);
        chk("to.late_stall", 64'(o_stall), 0);
        chk("to.err_hold",   64'(o_err), 1);
        chk("to.rd_hold",    64'(o_rd_data), 0);
        step();
        chk("to.late_idle_done", 64'(o_done), 0);

        // Misaligned word load from 0x101
`ifdef LSU_MISALIGN_TRAP_EN
        present(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        #1;
        chk("mis.stall", 64'(o_stall), 0);
        step();
        i_req_valid = 1'b0;
        #1;
        chk("mis.done", 64'(o_done), 1);
        chk("mis.flag", 64'(o_misalign), 1);
        chk("mis.mreq", 64'(o_mem_req_valid), 0);
        chk("mis.rdv",  64'(o_rd_valid), 0);
        chk("mis.rd",   64'(o_rd_data), 0);
        chk("mis.err",  64'(o_err), 0);
        step();
        chk("mis.idle_mreq", 64'(o_mem_req_valid), 0);
`else
        do_load("mis", 2'b10, 1'b0, 32'h101, 32'h100, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D);
        chk("mis.flag", 64'(o_misalign), 0);
        chk("mis.err",  64'(o_err), 0);
`endif

        // Reset asserted in WAIT
        do_load("pre", 2'b10, 1'b0, 32'h008, 32'h008, 4'hF, 32'h5555_AAAA, 32'h5555_AAAA);
        present(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        step();
        i_req_valid = 1'b0;
        step();
        chk("rst.wait_stall", 64'(o_stall), 1);
        i_reset_n = 1'b0;
        step();
        chk_all_zero("rst");
        i_reset_n = 1'b1;
        step();
        do_load("post", 2'b10, 1'b0, 32'h204, 32'h204, 4'hF, 32'h1122_3344, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
